// File: rtl/demux4_reg_if.sv
// demux4_reg_if: sample input, channel registers and status for the registered 1-to-4 demux
interface demux4_reg_if #(parameter int WIDTH = 1);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic [1:0]       sel;
    logic             auto;
    logic [WIDTH-1:0] o1, o2, o3, o4;
    logic [3:0]       v;
    logic             frame;
    logic [1:0]       ptr;
    modport master (output in, in_valid, sel, auto, input o1, o2, o3, o4, v, frame, ptr);
    modport slave (input in, in_valid, sel, auto, output o1, o2, o3, o4, v, frame, ptr);
endinterface

// File: rtl/demux4_reg.sv
// demux4_reg: steers each sample into one of four held registers by sel or a round-robin pointer
module demux4_reg #(parameter int WIDTH = 1) (
    input logic         clk,
    input logic         rst,
    demux4_reg_if.slave bus
);
    logic [WIDTH-1:0] r [4];
    logic [3:0]       v_q;
    logic             frame_q;
    logic [1:0]       ptr_q;
    logic [1:0]       ch;
    assign ch = bus.auto ? ptr_q : bus.sel;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r       <= '{default: '0};
            v_q     <= '0;
            frame_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            v_q     <= bus.in_valid ? 4'b0001 << ch : 4'b0000;
            frame_q <= bus.auto && bus.in_valid && ptr_q == 2'd3;
            // leaving auto mode abandons any partial frame
            ptr_q   <= !bus.auto ? 2'd0 : bus.in_valid ? ptr_q + 2'd1 : ptr_q;
            if (bus.in_valid) r[ch] <= bus.in;
        end
    assign bus.o1    = r[0];
    assign bus.o2    = r[1];
    assign bus.o3    = r[2];
    assign bus.o4    = r[3];
    assign bus.v     = v_q;
    assign bus.frame = frame_q;
    assign bus.ptr   = ptr_q;
endmodule

// File: doc/demux4_reg.md
# demux4_reg

Registered 1-to-4 demultiplexer: the distribution end of the registered 4:1 select path. A single input sample is steered to one of four held output registers, chosen either by an explicit select or by an internal round-robin counter that deals consecutive samples into a 4-sample frame. Per-channel valid strobes and a frame-complete pulse tell downstream logic which register was updated.

## Interface
- `WIDTH`, default 1: width of the data sample and of each output register.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in` input WIDTH: data sample.
- `in_valid` input 1: sample present this cycle. No backpressure; always accepted.
- `sel` input 2: target channel in manual mode (0→`o1`, 1→`o2`, 2→`o3`, 3→`o4`).
- `auto` input 1: 1 = round-robin mode, `sel` ignored; 0 = manual mode.
- `o1`, `o2`, `o3`, `o4` output WIDTH: held channel registers.
- `v` output 4: one-cycle update strobes; bit n set means channel n+1 was written at the last edge.
- `frame` output 1: one-cycle pulse when an auto-mode write to channel 3 (`o4`) completes a frame.
- `ptr` output 2: current round-robin pointer, for debug and verification.

## Operation
- Channel choice per cycle: `ch = auto ? ptr : sel`.
- On a rising edge with `in_valid=1`:
  - write `in` into channel `ch`;
  - set `v` to one-hot(`ch`);
  - other channels hold their values.
- On a rising edge with `in_valid=0`:
  - all channels hold;
  - `v` = 0 and `frame` = 0.
- Outputs are never cleared except by reset. They hold the last written value indefinitely.
- Round-robin pointer `ptr`:
  - if `auto=0`, `ptr` ← 0 (synchronously held at 0 while in manual mode);
  - if `auto=1` and `in_valid=1`, `ptr` ← `ptr`+1 modulo 4 (3 wraps to 0);
  - if `auto=1` and `in_valid=0`, `ptr` holds.
- `frame` ← 1 exactly when `auto=1`, `in_valid=1` and `ptr=3`; otherwise 0.
- Manual writes to channel 3 never assert `frame`.
- `auto` dropping mid-frame abandons the partial frame:
  - the next edge forces `ptr` to 0;
  - registers already written keep their values;
  - no `frame` pulse.
- `auto` rising in the same cycle as `in_valid`: that sample goes to channel `ptr`, which is 0 after any manual cycle.
- Reset (asserted at any time, including mid-frame) immediately forces:
  - `o1`..`o4` = 0, `v` = 0, `frame` = 0, `ptr` = 0.
  - Reset release performs no write. The first write happens at the first rising edge with `in_valid=1` after release.

## Timing
- Latency is 1 cycle: a sample presented with `in_valid` before edge k is visible on its output register after edge k. `v` and `frame` are asserted in the cycle that follows edge k.
- Throughput is one sample per clock, with no bubbles. Back-to-back valid samples in auto mode fill `o1`,`o2`,`o3`,`o4` on four consecutive edges. `frame` is high after the 4th edge.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.
- `v` is one-hot or zero at every cycle. `frame=1` implies `v=4'b1000`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle after loading all channels.
  - Required: `o1`..`o4`=0, `v`=0, `frame`=0, `ptr`=0 immediately, without waiting for a clock edge.
- Manual steering: `auto=0`, drive `in`=1 with `sel`=0,1,2,3 on four valid cycles, then `in`=0 with `sel`=2.
  - Required: `o1`..`o4`=1, then only `o3`=0.
  - Required: `v` sequence 0001, 0010, 0100, 1000, 0100.
  - Required: `frame` never asserts.
- Auto frame (WIDTH=4): `auto=1`, back-to-back valid samples A,B,C,D,E.
  - Required after 4 edges: `o1`=A, `o2`=B, `o3`=C, `o4`=D, `frame` pulses once with `v`=1000.
  - Required after the 5th edge: `o1`=E, `ptr`=1.
- Auto with gaps: `auto=1`, samples with `in_valid` low between them.
  - Required: `ptr` holds across idle cycles, `v`=0 while idle, and channels fill in order 0..3.
- Mode switch mid-frame: `auto=1`, two valid samples, drop `auto` for one cycle, raise it again with a valid sample X.
  - Required: X lands in `o1`, and no `frame` pulse occurs for the abandoned partial frame.
- Hold: 20 idle cycles after any write.
  - Required: all outputs stable and `v`=0.
